// File: rtl/sm_dm_arb.sv
// sm_dm_arb: shares one data-memory port between two requesters, one registered access per transfer.
// Optional build macro SM_DM_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins ties) instead of round-robin.
`ifndef WORD
`define WORD     2'b00
`endif
`ifndef HALFWORD
`define HALFWORD 2'b01
`endif
`ifndef BYTE
`define BYTE     2'b10
`endif

module sm_dm_arb #(
    parameter int unsigned DM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_da,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_da,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rd,
    output logic        dm_we,
    output logic [1:0]  dm_da,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    input  logic [31:0] dm_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic        win;
    logic        h_we, h_err;
    logic [1:0]  h_da;
    logic [31:0] h_addr, h_wd, rd_q;

    logic        sel, sel_we, sel_err, any_req;
    logic [1:0]  sel_da;
    logic [31:0] sel_addr, sel_wd;

    assign any_req = m0_req | m1_req;

`ifndef SM_DM_ARB_FIXED_PRIO_EN
    logic last_gnt;
`endif

    // Winner select and request validation on the live request fields
    always_comb begin
`ifdef SM_DM_ARB_FIXED_PRIO_EN
        sel = ~m0_req;
`else
        sel = (m0_req && m1_req) ? ~last_gnt : m1_req;
`endif
        sel_we   = sel ? m1_we   : m0_we;
        sel_da   = sel ? m1_da   : m0_da;
        sel_addr = sel ? m1_addr : m0_addr;
        sel_wd   = sel ? m1_wd   : m0_wd;
        sel_err  = 1'b0;
        case (sel_da)
            `WORD:     sel_err = (sel_addr[1:0] != 2'b00);
            `HALFWORD: sel_err = sel_addr[0];
            `BYTE:     sel_err = 1'b0;
            default:   sel_err = 1'b1;
        endcase
        if ({2'b00, sel_addr[31:2]} >= 32'(DM_WORDS))
            sel_err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        m0_done = 1'b0;
        m1_done = 1'b0;
        m0_err  = 1'b0;
        m1_err  = 1'b0;
        m0_rd   = '0;
        m1_rd   = '0;
        dm_we   = 1'b0;
        dm_da   = '0;
        dm_a    = '0;
        dm_wd   = '0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_next = ACCESS;
            end
            ACCESS: begin
                m0_gnt = ~win;
                m1_gnt = win;
                if (!h_err) begin
                    dm_we = h_we;
                    dm_da = h_da;
                    dm_a  = h_addr;
                    dm_wd = h_wd;
                end
                state_next = RESP;
            end
            RESP: begin
                if (win) begin
                    m1_done = 1'b1;
                    m1_err  = h_err;
                    m1_rd   = rd_q;
                end else begin
                    m0_done = 1'b1;
                    m0_err  = h_err;
                    m0_rd   = rd_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win    <= 1'b0;
            h_we   <= 1'b0;
            h_err  <= 1'b0;
            h_da   <= '0;
            h_addr <= '0;
            h_wd   <= '0;
            rd_q   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                win    <= sel;
                h_we   <= sel_we;
                h_err  <= sel_err;
                h_da   <= sel_da;
                h_addr <= sel_addr;
                h_wd   <= sel_wd;
            end
            if (state == ACCESS)
                rd_q <= (!h_we && !h_err) ? dm_rd : '0;
        end
    end

`ifndef SM_DM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= 1'b1;
        else if (state == IDLE && any_req)
            last_gnt <= sel;
    end
`endif

endmodule
